// File: rtl/flash_loader.sv
// Boot-time copier: issues one SPI NOR READ (0x03) and streams the returned bytes
// into the cache write port as little-endian 32-bit words, then releases the port.
module flash_loader #(
    parameter logic [7:0]  READ_CMD     = 8'h03,
    parameter int unsigned CLK_DIV      = 1,   // clk cycles per SPI half-period, >= 1
    parameter int unsigned STARTUP_WAIT = 10   // clk cycles before CS assertion, >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] flash_addr,
    input  logic [31:0] cache_base,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        flash_clk,
    output logic        flash_mosi,
    output logic        flash_cs,
    input  logic        flash_miso,
    output logic [31:0] cache_address,
    output logic [31:0] cache_data_in,
    output logic [3:0]  cache_write_enable,
    input  logic        cache_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STARTUP,
        S_CMD,
        S_ADDR,
        S_READ,
        S_WRITE,
        S_FINISH,
        S_DONE
    } state_t;

    localparam int DIV_W  = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
    localparam int WAIT_W = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARTUP_WAIT - 1);

    state_t              state, next_state;
    logic [23:0]         addr_q;
    logic [31:0]         base_q;
    logic [15:0]         wc_q;
    logic [15:0]         word_idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          bit_cnt;
    logic [31:0]         tx_sr;
    logic [31:0]         rx_sr;
    logic                wr_first;

    logic                shifting;
    logic                tick;
    logic                spi_rise;
    logic                spi_fall;
    logic [5:0]          bit_last_val;
    logic                last_bit;
    logic                word_last;
    logic [31:0]         wr_addr;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        shifting     = (state == S_CMD) || (state == S_ADDR) || (state == S_READ);
        tick         = (div_cnt == DIV_LAST);
        spi_rise     = shifting && tick && !flash_clk;
        spi_fall     = shifting && tick &&  flash_clk;
        bit_last_val = 6'd31;
        case (state)
            S_CMD:   bit_last_val = 6'd7;
            S_ADDR:  bit_last_val = 6'd23;
            default: bit_last_val = 6'd31;
        endcase
        last_bit  = (bit_cnt == bit_last_val);
        word_last = ((word_idx + 16'd1) == wc_q);
        // Base bits [1:0] are masked off; the offset never carries out of them.
        wr_addr   = (base_q + {14'd0, word_idx, 2'b00}) & 32'hFFFF_FFFC;

        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = (word_count == 16'd0) ? S_FINISH : S_STARTUP;
            S_STARTUP: if (wait_cnt == WAIT_LAST) next_state = S_CMD;
            S_CMD:     if (spi_fall && last_bit) next_state = S_ADDR;
            S_ADDR:    if (spi_fall && last_bit) next_state = S_READ;
            S_READ:    if (spi_fall && last_bit) next_state = S_WRITE;
            S_WRITE:   if (!wr_first && !cache_busy) next_state = word_last ? S_FINISH : S_READ;
            S_FINISH:  next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            flash_cs           <= 1'b1;
            flash_clk          <= 1'b0;
            flash_mosi         <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            cache_write_enable <= 4'b0000;
            cache_address      <= 32'd0;
            cache_data_in      <= 32'd0;
            addr_q             <= 24'd0;
            base_q             <= 32'd0;
            wc_q               <= 16'd0;
            word_idx           <= 16'd0;
            wait_cnt           <= '0;
            div_cnt            <= '0;
            bit_cnt            <= 6'd0;
            tx_sr              <= 32'd0;
            rx_sr              <= 32'd0;
            wr_first           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= flash_addr;
                        base_q   <= cache_base;
                        wc_q     <= word_count;
                        word_idx <= 16'd0;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_STARTUP: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (next_state == S_CMD) begin
                        flash_cs   <= 1'b0;
                        flash_clk  <= 1'b0;
                        flash_mosi <= READ_CMD[7];
                        tx_sr      <= {READ_CMD[6:0], addr_q, 1'b0};
                        div_cnt    <= '0;
                        bit_cnt    <= 6'd0;
                    end
                end
                S_CMD, S_ADDR, S_READ: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                    if (spi_rise) begin
                        flash_clk <= 1'b1;
                        rx_sr     <= {rx_sr[30:0], flash_miso};
                    end
                    // Falling SCLK launches the next MOSI bit; after the address the shifter is all zeros.
                    if (spi_fall) begin
                        flash_clk  <= 1'b0;
                        flash_mosi <= tx_sr[31];
                        tx_sr      <= {tx_sr[30:0], 1'b0};
                        bit_cnt    <= last_bit ? 6'd0 : bit_cnt + 6'd1;
                        if (state == S_READ && last_bit) begin
                            cache_address      <= wr_addr;
                            cache_data_in      <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                            cache_write_enable <= 4'b1111;
                            wr_first           <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    wr_first <= 1'b0;
                    if (next_state != S_WRITE) begin
                        cache_write_enable <= 4'b0000;
                        word_idx           <= word_idx + 16'd1;
                        if (next_state == S_FINISH) begin
                            flash_cs  <= 1'b1;
                            flash_clk <= 1'b0;
                        end
                    end
                end
                S_FINISH: done <= 1'b1;
                S_DONE:   busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_loader.sv
// Scoreboard bench for flash_loader: a behavioural SPI flash feeds bytes, a monitor
// checks every cache write against the expectation queue filled by the stimulus.
module tb_flash_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] flash_addr = 24'd0;
    logic [31:0] cache_base = 32'd0;
    logic [15:0] word_count = 16'd0;
    logic        flash_miso = 1'b0;
    logic        cache_busy = 1'b0;
    logic        busy, done, flash_clk, flash_mosi, flash_cs;
    logic [31:0] cache_address, cache_data_in;
    logic [3:0]  cache_write_enable;

    flash_loader #(.READ_CMD(8'h03), .CLK_DIV(1), .STARTUP_WAIT(10)) dut (
        .clk(clk), .rst(rst), .start(start), .flash_addr(flash_addr),
        .cache_base(cache_base), .word_count(word_count), .busy(busy), .done(done),
        .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_cs(flash_cs),
        .flash_miso(flash_miso), .cache_address(cache_address),
        .cache_data_in(cache_data_in), .cache_write_enable(cache_write_enable),
        .cache_busy(cache_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          hold;
    } wr_exp_t;
    wr_exp_t exp_q[$];

    // Behavioural flash: shifts in cmd+addr on SCLK rise, drives data bits on SCLK fall.
    logic [7:0]  flash_mem [0:15];
    int          m_bits = 0;
    logic [31:0] m_cmd_addr = 32'd0;
    int          cs_falls = 0;

    always @(negedge flash_cs or posedge flash_clk) begin
        if (!flash_clk) begin
            m_bits     = 0;
            m_cmd_addr = 32'd0;
            cs_falls++;
        end else if (!flash_cs) begin
            if (m_bits < 32) m_cmd_addr = {m_cmd_addr[30:0], flash_mosi};
            m_bits++;
        end
    end

    always @(negedge flash_clk) begin
        if (!flash_cs && m_bits >= 32)
            flash_miso = flash_mem[((m_bits - 32) / 8) % 16][7 - ((m_bits - 32) % 8)];
    end

    // Monitor: write scoreboard, cache_busy responder, done and SCLK period tracking.
    int      done_cnt = 0;
    int      wr_cnt = 0;
    int      per_bad = 0;
    int      per_seen = 0;
    bit      busy_mode = 1'b0;

    initial begin
        logic    we_prev, clk_prev;
        int      wr_len, per_cnt, busy_left;
        wr_exp_t cur;
        we_prev = 1'b0; clk_prev = 1'b0; wr_len = 0; per_cnt = 0; busy_left = 0;
        cur = '{addr: 32'd0, data: 32'd0, hold: 0};
        forever begin
            @(negedge clk);
            if (cache_write_enable != 4'b0000 && !we_prev) begin
                wr_cnt++;
                wr_len = 1;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             cache_address, cache_data_in);
                end else begin
                    cur = exp_q.pop_front();
                    check("write_addr", cache_address, cur.addr);
                    check("write_data", cache_data_in, cur.data);
                    check("write_we", cache_write_enable, 4'b1111);
                end
                if (busy_mode) begin
                    cache_busy = 1'b1;
                    busy_left  = 5;
                end
            end else begin
                if (cache_write_enable != 4'b0000) wr_len++;
                else if (we_prev) check("write_hold", wr_len, cur.hold);
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) cache_busy = 1'b0;
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_with_done", busy, 1'b1);
            end
            per_cnt++;
            if (flash_clk && !clk_prev) begin
                if (m_bits >= 2 && m_bits <= 32) begin
                    per_seen++;
                    if (per_cnt != 2) per_bad++;
                end
                per_cnt = 0;
            end
            we_prev  = (cache_write_enable != 4'b0000);
            clk_prev = flash_clk;
        end
    end

    task automatic pulse_start(input logic [23:0] a, input logic [31:0] b, input logic [15:0] wc);
        @(negedge clk);
        flash_addr = a; cache_base = b; word_count = wc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int prev);
        int k = 0;
        while (done_cnt == prev && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check(name, done_cnt - prev, 1);
        @(negedge clk);
        @(negedge clk);
        check({name, "_idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int d0, w0, c0, ps0, pb0, k;
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, w0, c0, ps0, pb0, k;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {flash_cs, flash_clk, flash_mosi, busy, done, cache_write_enable}, 9'b1_0000_0000);
        check("reset_addr", cache_address, 32'd0);
        check("reset_data", cache_data_in, 32'd0);
        rst = 1'b0;

        // Single word: command/address stream, SCLK period, little-endian assembly.
        flash_mem[0] = 8'h11; flash_mem[1] = 8'h22; flash_mem[2] = 8'h33; flash_mem[3] = 8'h44;
        exp_q.push_back('{addr: 32'h0000_1000, data: 32'h4433_2211, hold: 2});
        d0 = done_cnt; w0 = wr_cnt; c0 = cs_falls; ps0 = per_seen; pb0 = per_bad;
        pulse_start(24'h000100, 32'h0000_1000, 16'd1);
        check("busy_after_start", busy, 1'b1);
        wait_done("one_word_done", d0);
        check("one_word_cmd_addr", m_cmd_addr, 32'h0300_0100);
        check("one_word_sclk_periods", per_seen - ps0, 31);
        check("one_word_sclk_bad", per_bad - pb0, 0);
        check("one_word_cs_once", cs_falls - c0, 1);
        check("one_word_writes", wr_cnt - w0, 1);

        // Four words with a slow cache: each write held 6 cycles.
        for (int i = 0; i < 16; i++) flash_mem[i] = 8'h10 + 8'(i);
        exp_q.push_back('{addr: 32'h0000_0100, data: 32'h1312_1110, hold: 6});
        exp_q.push_back('{addr: 32'h0000_0104, data: 32'h1716_1514, hold: 6});
        exp_q.push_back('{addr: 32'h0000_0108, data: 32'h1B1A_1918, hold: 6});
        exp_q.push_back('{addr: 32'h0000_010C, data: 32'h1F1E_1D1C, hold: 6});
        busy_mode = 1'b1;
        d0 = done_cnt; w0 = wr_cnt; c0 = cs_falls;
        pulse_start(24'h000200, 32'h0000_0100, 16'd4);
        wait_done("four_word_done", d0);
        busy_mode = 1'b0;
        check("four_word_cmd_addr", m_cmd_addr, 32'h0300_0200);
        check("four_word_writes", wr_cnt - w0, 4);
        check("four_word_cs_once", cs_falls - c0, 1);
        check("four_word_queue_empty", exp_q.size(), 0);

        // Zero words: done within two cycles, chip select untouched.
        c0 = cs_falls; d0 = done_cnt;
        pulse_start(24'h000300, 32'h0000_2000, 16'd0);
        @(negedge clk);
        check("zero_word_done_2cyc", done, 1'b1);
        @(negedge clk);
        check("zero_word_idle", {busy, done}, 2'b00);
        check("zero_word_no_cs", cs_falls - c0, 0);

        // Start during an active load is ignored; misaligned base bits dropped.
        for (int i = 0; i < 16; i++) flash_mem[i] = 8'hA0 + 8'(i);
        exp_q.push_back('{addr: 32'h0000_0200, data: 32'hA3A2_A1A0, hold: 2});
        exp_q.push_back('{addr: 32'h0000_0204, data: 32'hA7A6_A5A4, hold: 2});
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start(24'h000040, 32'h0000_0203, 16'd2);
        repeat (20) @(negedge clk);
        pulse_start(24'hABCDEF, 32'h0000_0900, 16'd5);
        wait_done("restart_ignored_done", d0);
        check("restart_ignored_cmd_addr", m_cmd_addr, 32'h0300_0040);
        check("restart_ignored_writes", wr_cnt - w0, 2);
        check("restart_ignored_queue_empty", exp_q.size(), 0);

        // Reset in the middle of the first READ word.
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start(24'h000000, 32'h0000_0000, 16'd2);
        k = 0;
        while (m_bits < 40 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        check("mid_read_reached", m_bits >= 40, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", {flash_cs, busy, cache_write_enable}, 6'b10_0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_write", wr_cnt - w0, 0);
        check("abort_cs_high", flash_cs, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
